// File: rtl/pipe_rca_param.sv
// Parametrised pipelined ripple-carry adder/subtractor: SLICE bits per stage,
// WIDTH/SLICE stages, valid tag, global enable and signed-overflow flag.
module pipe_rca_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / SLICE;

    if (WIDTH % SLICE != 0) begin : g_bad_param
        $error("pipe_rca_param: WIDTH must be an integer multiple of SLICE");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction as a + ~b + 1; cin is ignored in that mode.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned WIn  = WIDTH - k * SLICE;
        localparam int unsigned WSum = (k + 1) * SLICE;

        logic [WIn-1:0]   a_cur;
        logic [WIn-1:0]   b_cur;
        logic             c_cur;
        logic             v_cur;
        logic [SLICE-1:0] s_slice;
        logic [SLICE:0]   c_chain;
        logic [WSum-1:0]  sum_next;

        logic             valid_q;
        logic             carry_q;
        logic [WSum-1:0]  sum_q;

        if (k == 0) begin : g_first
            assign a_cur    = a;
            assign b_cur    = b_eff;
            assign c_cur    = c_eff;
            assign v_cur    = in_valid;
            assign sum_next = s_slice;
        end else begin : g_next
            assign a_cur    = g_stage[k-1].g_fwd.a_q;
            assign b_cur    = g_stage[k-1].g_fwd.b_q;
            assign c_cur    = g_stage[k-1].carry_q;
            assign v_cur    = g_stage[k-1].valid_q;
            // New slice goes on top of the already-resolved lower slices.
            assign sum_next = {s_slice, g_stage[k-1].sum_q};
        end

        always_comb begin
            c_chain    = '0;
            s_slice    = '0;
            c_chain[0] = c_cur;
            for (int i = 0; i < SLICE; i++) begin
                s_slice[i]   = a_cur[i] ^ b_cur[i] ^ c_chain[i];
                c_chain[i+1] = (a_cur[i] & b_cur[i]) | (c_chain[i] & (a_cur[i] ^ b_cur[i]));
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en) begin
                valid_q <= v_cur;
                carry_q <= c_chain[SLICE];
                sum_q   <= sum_next;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Operand bits not yet consumed; shrinks by SLICE every stage.
            logic [WIn-SLICE-1:0] a_q;
            logic [WIn-SLICE-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_cur[WIn-1:SLICE];
                    b_q <= b_cur[WIn-1:SLICE];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= c_chain[SLICE] ^ c_chain[SLICE-1];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_rca_param.sv
// Directed self-checking bench for pipe_rca_param: a 4-stage build (16/4)
// and a single-stage build (16/16) sharing one stimulus stream.
module tb_pipe_rca_param;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;

    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        out_valid1;
    logic [15:0] sum1;
    logic        cout1;
    logic        ovf1;

    int total;
    int bad;

    pipe_rca_param #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    pipe_rca_param #(.WIDTH(16), .SLICE(16)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                          input logic c, input logic s);
        in_valid = v;
        a        = aa;
        b        = bb;
        cin      = c;
        sub      = s;
    endtask

    // Zero-data bubbles leave every pipeline register at a known all-zero value.
    task automatic flush();
        en = 1'b1;
        set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [15:0] ra;
        logic [15:0] rb;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rst = (i < 2);
            ra  = 16'($urandom());
            rb  = 16'($urandom());
            set_op(1'b1, ra, rb, 1'($urandom()), 1'($urandom()));
            tick();
            total++;
            if ({out_valid, sum, cout, ovf} !== 19'h0) begin
                bad++;
                $display("FAIL reset[%0d] got %h want %h", i, {out_valid, sum, cout, ovf}, 19'h0);
            end
            if (i == 1) begin
                total++;
                if ({out_valid1, sum1, cout1, ovf1} !== 19'h0) begin
                    bad++;
                    $display("FAIL reset_s1 got %h want %h", {out_valid1, sum1, cout1, ovf1},
                             19'h0);
                end
            end
        end
        rst = 1'b0;
        flush();
    endtask

    task automatic test_latency();
        for (int i = 0; i < 7; i++) begin
            if (i == 0) set_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
            else        set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            total++;
            if (i == 3) begin
                if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL latency[%0d] got %h want %h", i, {out_valid, sum, cout, ovf},
                             {1'b1, 16'h0000, 1'b1, 1'b0});
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL latency_idle[%0d] got out_valid=%b want 0", i, out_valid);
            end
        end
        flush();
    endtask

    task automatic run_three(input string name, input logic s, input logic c,
                             input logic [15:0] va [3], input logic [15:0] vb [3],
                             input logic [18:0] exp [3]);
        for (int i = 0; i < 8; i++) begin
            if (i < 3) set_op(1'b1, va[i], vb[i], c, s);
            else       set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            total++;
            if (i >= 3 && i <= 5) begin
                if ({out_valid, sum, cout, ovf} !== exp[i-3]) begin
                    bad++;
                    $display("FAIL %s[%0d] got %h want %h", name, i - 3,
                             {out_valid, sum, cout, ovf}, exp[i-3]);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s_idle[%0d] got out_valid=%b want 0", name, i, out_valid);
            end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [18:0] exp [3];
        va  = '{16'h1234, 16'h7FFF, 16'h00FF};
        vb  = '{16'h4321, 16'h0001, 16'h0000};
        exp = '{{1'b1, 16'h5555, 1'b0, 1'b0},
                {1'b1, 16'h8000, 1'b0, 1'b1},
                {1'b1, 16'h0100, 1'b0, 1'b0}};
        // Third op needs cin=1; first two are unaffected only if cin=0, so split.
        for (int i = 0; i < 8; i++) begin
            if (i < 3) set_op(1'b1, va[i], vb[i], (i == 2), 1'b0);
            else       set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            total++;
            if (i >= 3 && i <= 5) begin
                if ({out_valid, sum, cout, ovf} !== exp[i-3]) begin
                    bad++;
                    $display("FAIL b2b[%0d] got %h want %h", i - 3,
                             {out_valid, sum, cout, ovf}, exp[i-3]);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle[%0d] got out_valid=%b want 0", i, out_valid);
            end
        end
        flush();
    endtask

    task automatic test_subtract();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [18:0] exp [3];
        va  = '{16'h0005, 16'h8000, 16'h1234};
        vb  = '{16'h0007, 16'h0001, 16'h1234};
        exp = '{{1'b1, 16'hFFFE, 1'b0, 1'b0},
                {1'b1, 16'h7FFF, 1'b1, 1'b1},
                {1'b1, 16'h0000, 1'b1, 1'b0}};
        run_three("sub", 1'b1, 1'b1, va, vb, exp);
    endtask

    task automatic test_stall();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [18:0] exp [4];
        va  = '{16'h0001, 16'h1111, 16'hF000, 16'h4000};
        vb  = '{16'h0002, 16'h2222, 16'h1000, 16'h4000};
        exp = '{{1'b1, 16'h0003, 1'b0, 1'b0},
                {1'b1, 16'h3333, 1'b0, 1'b0},
                {1'b1, 16'h0000, 1'b1, 1'b0},
                {1'b1, 16'h8000, 1'b0, 1'b1}};
        for (int e = 0; e < 12; e++) begin
            en = 1'b1;
            if (e == 0 || e == 1) begin
                set_op(1'b1, va[e], vb[e], 1'b0, 1'b0);
            end else if (e >= 2 && e <= 4) begin
                en = 1'b0;
                set_op(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()));
            end else if (e == 5 || e == 6) begin
                set_op(1'b1, va[e-3], vb[e-3], 1'b0, 1'b0);
            end else begin
                set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            end
            tick();
            total++;
            if (e <= 5) begin
                if ({out_valid, sum, cout, ovf} !== 19'h0) begin
                    bad++;
                    $display("FAIL stall_hold[%0d] got %h want %h", e,
                             {out_valid, sum, cout, ovf}, 19'h0);
                end
            end else if (e <= 9) begin
                if ({out_valid, sum, cout, ovf} !== exp[e-6]) begin
                    bad++;
                    $display("FAIL stall_out[%0d] got %h want %h", e - 6,
                             {out_valid, sum, cout, ovf}, exp[e-6]);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_idle[%0d] got out_valid=%b want 0", e, out_valid);
            end
        end
        flush();
    endtask

    task automatic test_mid_reset();
        en = 1'b1;
        for (int e = 0; e < 13; e++) begin
            rst = (e == 3);
            if (e < 3)       set_op(1'b1, 16'h0100 + 16'(e), 16'h0011, 1'b0, 1'b0);
            else if (e == 8) set_op(1'b1, 16'h2000, 16'h0FFF, 1'b1, 1'b0);
            else             set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            total++;
            if (e == 11) begin
                if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h3000, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL mid_reset_next got %h want %h", {out_valid, sum, cout, ovf},
                             {1'b1, 16'h3000, 1'b0, 1'b0});
                end
            end else if (e >= 3 && out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_idle[%0d] got out_valid=%b want 0", e, out_valid);
            end else if (e < 3 && out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_fill[%0d] got out_valid=%b want 0", e, out_valid);
            end
        end
        rst = 1'b0;
        flush();
    endtask

    task automatic test_stages1();
        logic [18:0] exp [3];
        exp = '{{1'b1, 16'h0000, 1'b1, 1'b0},
                {1'b1, 16'h8000, 1'b0, 1'b1},
                {1'b0, 16'h0000, 1'b0, 1'b0}};
        en = 1'b1;
        for (int e = 0; e < 3; e++) begin
            if (e == 0)      set_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
            else if (e == 1) set_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
            else             set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            total++;
            if ({out_valid1, sum1, cout1, ovf1} !== exp[e]) begin
                bad++;
                $display("FAIL stages1[%0d] got %h want %h", e,
                         {out_valid1, sum1, cout1, ovf1}, exp[e]);
            end
        end
        flush();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b1;
        set_op(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        test_reset();
        test_latency();
        test_back_to_back();
        test_subtract();
        test_stall();
        test_mid_reset();
        test_stages1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_rca_param.md
Name: pipe_rca_param

Overview:
- Parametrised pipelined ripple-carry adder/subtractor. It is the successor to the fixed 4-bit, 1-bit-per-stage pipelined RCA.
- Operand width and bits-per-stage are generic. Adds a valid tag, a global stall/clock-enable, an add/sub mode and a signed-overflow flag.
- Sits in datapath pipelines that need full throughput (one op per cycle) at a short carry chain per stage.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- SLICE, 4, bits resolved per pipeline stage. WIDTH must be an integer multiple of SLICE; otherwise elaboration fails.
- STAGES, WIDTH/SLICE, derived (localparam). Pipeline depth and latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  pipeline advance enable. 0 freezes every register.
- in_valid  in  1  a, b, cin, sub are valid this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Used only when sub=0.
- sub  in  1  0: a+b+cin. 1: a-b, computed as a+~b+1; cin ignored.
- out_valid  out  1  sum, cout, ovf are valid.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of MSB. In sub mode, 1 means no borrow (a>=b unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a clk edge): all pipeline registers and outputs become 0, including out_valid, sum, cout and ovf.
  - rst has priority over en.
  - In-flight operations are discarded; they never appear at the output.
- Operand conditioning is combinational at input:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? 1 : cin.
- Stage k (0..STAGES-1) resolves bits [k*SLICE +: SLICE] with a SLICE-bit ripple chain.
  - Input to stage k is the carry registered by stage k-1; stage 0 uses c_eff.
  - Unconsumed upper operand bits are forwarded in a shrinking skew register.
  - Already-computed lower sum slices are forwarded in a growing deskew register.
  - All slices of one operation therefore leave the pipeline in the same cycle.
- Final stage:
  - Registers sum, cout, and ovf = (carry into bit WIDTH-1) ^ cout.
  - The carry into bit WIDTH-1 is taken inside the final slice chain.
- Valid tag travels with the data through a STAGES-deep shift register.
- Latency: an op presented with en=1 on edge N appears on the outputs after edge N+STAGES-1. Outputs are registered, so output is visible in the cycle following that edge.
  - Sustained throughput is 1 op/cycle with no bubbles required.
- Stall: en=0 at an edge leaves every register, including outputs, unchanged.
  - Inputs presented while en=0 are ignored (not captured).
  - Latency in cycles grows by the number of stalled edges; no op is lost or duplicated.
- in_valid=0 cycles propagate as bubbles (out_valid=0).
  - Data registers are still clocked when en=1; bubble data content is don't-care.
- STAGES=1 (SLICE=WIDTH) is legal: a single registered full-width adder with latency 1.
- Wrap-around: sum is truncated to WIDTH bits; the overflow is reported only via cout and ovf.
- No backpressure input beyond en. The consumer must accept out_valid whenever en=1.

Test Plan:
- Reset: hold rst=1 for 2 edges with in_valid=1 and random operands -> out_valid=0, sum=0, cout=0, ovf=0 for the full reset and STAGES-1 cycles after.
- Latency/carry (WIDTH=16, SLICE=4): a=0xFFFF, b=0x0001, cin=0, sub=0 at edge 0 -> after edge 3: out_valid=1, sum=0x0000, cout=1, ovf=0. out_valid=0 at all other edges.
- Back-to-back stream on consecutive edges -> results on consecutive cycles in order:
  - 0x1234+0x4321+0 -> 0x5555 c0 v0.
  - 0x7FFF+0x0001+0 -> 0x8000 c0 v1.
  - 0x00FF+0x0000+1 -> 0x0100 c0 v0.
- Subtract: sub=1 with cin=1 (must be ignored):
  - 0x0005-0x0007 -> 0xFFFE c0 v0.
  - 0x8000-0x0001 -> 0x7FFF c1 v1.
  - 0x1234-0x1234 -> 0x0000 c1 v0.
- Stall: stream 4 ops, drop en for 3 edges after the second input while driving garbage inputs -> outputs frozen during the stall. All 4 correct results appear exactly once; the last arrives 3 cycles later than unstalled.
- Mid-flight reset plus STAGES=1 build:
  - Issue 3 ops, pulse rst for 1 edge -> none emerge; the next op issued after reset emerges at normal latency.
  - Repeat the carry test with SLICE=16 -> result after 1 edge.
